fetch_align: RTL and testbench

Instruction fetch aligner that sequences the instruction decompressor. It fetches word-aligned 32-bit words from instruction memory and keeps a halfword-granular buffer. Each cycle it presents a 32-bit instruction window, starting at the current PC, to the decompressor and the decode stage. It uses the decompressor's `compressed` flag to retire 2 or 4 bytes per instruction, so 16-bit and 32-bit instructions at any halfword alignment, including ones that straddle a word boundary, reach decode correctly.

---
 rtl/fetch_align.sv | 132 +++++++++++++
 tb/tb_fetch_align.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fetch_align.sv
// ============================================================================
// fetch_align : halfword-granular fetch aligner feeding the decompressor | rev 1.0
// ============================================================================
`default_nettype none

module fetch_align #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        compressed
);

  logic [15:0] hw_q [4];
  logic [15:0] hw_d [4];
  logic [15:0] hw_sh [4];
  logic [2:0]  cnt_q, cnt_d, cnt_c;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fpc_q, fpc_d;
  logic [31:0] hold_q;
  logic        skip_q, skip_d;
  logic        drop_q, drop_d;

  logic        valid_raw;
  logic        ack;
  logic        fill;
  logic        take;
  logic [2:0]  n_take;

  always_comb begin
    valid_raw = (cnt_q >= 3'd2) || (cnt_q == 3'd1 && hw_q[0][1:0] != 2'b11);
    instr_valid = valid_raw && !reset && !redirect && !drop_q;
    instr_pc    = pc_q;
    if (reset || cnt_q == 3'd0) begin
      instr_out = 32'h0;
    end else if (cnt_q == 3'd1) begin
      instr_out = {16'h0, hw_q[0]};
    end else begin
      instr_out = {hw_q[1], hw_q[0]};
    end
    mem_req = !reset && (cnt_q <= 3'd2 || drop_q);
    // A dropped request must keep presenting its original address until acked.
    mem_addr = drop_q ? hold_q : fpc_q;
    ack      = mem_req && mem_ack;
    fill     = ack && !drop_q;
    take     = instr_valid && instr_ready;
    n_take   = take ? (compressed ? 3'd1 : 3'd2) : 3'd0;
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      hw_sh[i] = hw_q[i];
    end
    case (n_take)
      3'd1: begin
        hw_sh[0] = hw_q[1];
        hw_sh[1] = hw_q[2];
        hw_sh[2] = hw_q[3];
      end
      3'd2: begin
        hw_sh[0] = hw_q[2];
        hw_sh[1] = hw_q[3];
      end
      default: ;
    endcase
    cnt_c = cnt_q - n_take;

    for (int i = 0; i < 4; i++) begin
      hw_d[i] = hw_sh[i];
      if (fill) begin
        if (skip_q) begin
          if (3'(i) == cnt_c) hw_d[i] = mem_rdata[31:16];
        end else begin
          if (3'(i) == cnt_c)         hw_d[i] = mem_rdata[15:0];
          if (3'(i) == cnt_c + 3'd1)  hw_d[i] = mem_rdata[31:16];
        end
      end
    end

    cnt_d  = cnt_c + (fill ? (skip_q ? 3'd1 : 3'd2) : 3'd0);
    pc_d   = pc_q + (take ? (compressed ? 32'd2 : 32'd4) : 32'd0);
    fpc_d  = fill ? fpc_q + 32'd4 : fpc_q;
    skip_d = fill ? 1'b0 : skip_q;
    drop_d = drop_q && !ack;

    if (redirect) begin
      cnt_d  = 3'd0;
      pc_d   = redirect_pc & 32'hFFFF_FFFE;
      fpc_d  = redirect_pc & 32'hFFFF_FFFC;
      skip_d = redirect_pc[1];
      // Acked in this very cycle means nothing is left outstanding to discard.
      drop_d = mem_req && !mem_ack;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        hw_q[i] <= 16'h0;
      end
      cnt_q  <= 3'd0;
      pc_q   <= RESET_PC;
      fpc_q  <= RESET_PC & 32'hFFFF_FFFC;
      hold_q <= RESET_PC & 32'hFFFF_FFFC;
      skip_q <= RESET_PC[1];
      drop_q <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        hw_q[i] <= hw_d[i];
      end
      cnt_q  <= cnt_d;
      pc_q   <= pc_d;
      fpc_q  <= fpc_d;
      hold_q <= mem_addr;
      skip_q <= skip_d;
      drop_q <= drop_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_align.sv
// ============================================================================
// tb_fetch_align : directed vector table plus hand-written corner sequences | rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_align;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        compressed = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  fetch_align #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .compressed  (compressed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ack;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        cmp;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_out;
    logic [31:0] e_pc;
    logic        ca;
    logic        ci;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int rst, input int ack, input logic [31:0] rdata,
                     input int redir, input logic [31:0] rpc, input int rdy, input int cmp,
                     input int e_req, input logic [31:0] e_addr, input int e_val,
                     input logic [31:0] e_out, input logic [31:0] e_pc,
                     input int ca, input int ci);
    vec_t t;
    t.rst = (rst != 0);   t.ack = (ack != 0);  t.rdata = rdata;
    t.redir = (redir != 0); t.rpc = rpc;
    t.rdy = (rdy != 0);   t.cmp = (cmp != 0);
    t.e_req = (e_req != 0); t.e_addr = e_addr; t.e_val = (e_val != 0);
    t.e_out = e_out;      t.e_pc = e_pc;
    t.ca = (ca != 0);     t.ci = (ci != 0);
    vq.push_back(t);
  endtask

  task automatic chk(input int idx, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL step %0d %s: got %h expected %h", idx, nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs on the falling edge, then settle before sampling.
  task automatic step(input logic rst, input logic ack, input logic [31:0] rdata,
                      input logic redir, input logic [31:0] rpc, input logic rdy, input logic cmp);
    @(negedge clk);
    reset = rst; mem_ack = ack; mem_rdata = rdata;
    redirect = redir; redirect_pc = rpc;
    instr_ready = rdy; compressed = cmp;
    #1;
  endtask

  initial begin
    // reset
    add(1,0,0,0,0,0,0,                 0,0,0,0,0, 0,0);
    add(1,0,0,0,0,0,0,                 0,0,0,0,0, 1,1);
    // first fetch
    add(0,1,32'h13,0,0,0,0,            1,0,0,0,0, 1,1);
    add(0,0,0,0,0,1,0,                 1,4,1,32'h13,0, 1,1);
    // redirect to 0 with same-cycle ack: data discarded
    add(0,1,32'hDEADBEEF,1,0,0,0,      1,4,0,0,4, 1,1);
    // mixed stream c.li, c.li, addi
    add(0,1,32'h45014581,0,0,0,0,      1,0,0,0,0, 1,1);
    add(0,1,32'h00100513,0,0,1,1,      1,4,1,32'h45014581,0, 1,1);
    add(0,0,0,0,0,1,1,                 0,8,1,32'h05134501,2, 1,1);
    add(0,0,0,0,0,1,0,                 1,8,1,32'h00100513,4, 1,1);
    // straddling 32-bit instruction
    add(0,1,32'hFFFFFFFF,1,0,0,0,      1,8,0,0,8, 1,1);
    add(0,1,32'h05134581,0,0,0,0,      1,0,0,0,0, 1,1);
    add(0,0,0,0,0,1,1,                 1,4,1,32'h05134581,0, 1,1);
    add(0,0,0,0,0,1,0,                 1,4,0,32'h00000513,2, 1,1);
    add(0,1,32'h45810010,0,0,1,0,      1,4,0,32'h00000513,2, 1,1);
    add(0,0,0,0,0,1,0,                 0,8,1,32'h00100513,2, 1,1);
    add(0,0,0,0,0,1,1,                 1,8,1,32'h00004581,6, 1,1);
    // redirect to 0x102: lower half skipped
    add(0,1,32'hAAAAAAAA,1,32'h102,0,0, 1,8,0,0,8, 1,1);
    add(0,1,32'h12344581,0,0,0,0,      1,32'h100,0,0,32'h102, 1,1);
    add(0,0,0,0,0,0,0,                 1,32'h104,1,32'h1234,32'h102, 1,1);
    // redirect while request at 0x104 is pending
    add(0,0,0,1,32'h200,0,0,           1,32'h104,0,32'h1234,32'h102, 1,1);
    add(0,0,0,0,0,0,0,                 1,32'h104,0,0,32'h200, 1,1);
    add(0,1,32'hBEEF0013,0,0,0,0,      1,32'h104,0,0,32'h200, 1,1);
    add(0,1,32'h00000001,0,0,0,0,      1,32'h200,0,0,32'h200, 1,1);
    // backpressure fills buffer to 4
    add(0,1,32'h00050009,0,0,0,0,      1,32'h204,1,32'h1,32'h200, 1,1);
    add(0,0,0,0,0,0,0,                 0,32'h208,1,32'h1,32'h200, 1,1);
    add(0,0,0,0,0,1,1,                 0,32'h208,1,32'h1,32'h200, 1,1);
    add(0,0,0,0,0,1,1,                 0,32'h208,1,32'h00090000,32'h202, 1,1);
    // wrap at top of address space
    add(0,1,32'h11111111,1,32'hFFFFFFFC,0,0, 1,32'h208,0,32'h00050009,32'h204, 1,1);
    add(0,1,32'h00050001,0,0,0,0,      1,32'hFFFFFFFC,0,0,32'hFFFFFFFC, 1,1);
    add(0,1,32'h00110015,0,0,1,1,      1,0,1,32'h00050001,32'hFFFFFFFC, 1,1);
    add(0,0,0,0,0,1,1,                 0,4,1,32'h00150005,32'hFFFFFFFE, 1,1);
    add(0,0,0,0,0,0,0,                 1,4,1,32'h00110015,0, 1,1);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].rst, vq[i].ack, vq[i].rdata, vq[i].redir, vq[i].rpc, vq[i].rdy, vq[i].cmp);
      chk(i, "mem_req", 32'(mem_req), 32'(vq[i].e_req));
      chk(i, "instr_valid", 32'(instr_valid), 32'(vq[i].e_val));
      chk(i, "instr_out", instr_out, vq[i].e_out);
      if (vq[i].ca) chk(i, "mem_addr", mem_addr, vq[i].e_addr);
      if (vq[i].ci) chk(i, "instr_pc", instr_pc, vq[i].e_pc);
    end

    // reset mid-stream, then two back-to-back redirects over one pending request
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk(100, "rst_req", 32'(mem_req), 32'h0);
    chk(100, "rst_valid", 32'(instr_valid), 32'h0);
    chk(100, "rst_out", instr_out, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 1'b0);
    chk(101, "post_rst_req", 32'(mem_req), 32'h1);
    chk(101, "post_rst_addr", mem_addr, 32'h0);
    chk(101, "post_rst_pc", instr_pc, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h80, 1'b0, 1'b0);
    chk(102, "held_addr", mem_addr, 32'h0);
    chk(102, "held_req", 32'(mem_req), 32'h1);
    step(1'b0, 1'b1, 32'h99999999, 1'b0, 32'h0, 1'b0, 1'b0);
    chk(103, "drop_addr", mem_addr, 32'h0);
    chk(103, "drop_valid", 32'(instr_valid), 32'h0);
    step(1'b0, 1'b1, 32'h00000005, 1'b0, 32'h0, 1'b1, 1'b1);
    chk(104, "new_addr", mem_addr, 32'h80);
    chk(104, "new_pc", instr_pc, 32'h80);
    chk(104, "new_valid", 32'(instr_valid), 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk(105, "new_out_valid", 32'(instr_valid), 32'h1);
    chk(105, "new_out", instr_out, 32'h00000005);
    chk(105, "new_out_pc", instr_pc, 32'h80);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
